// File: rtl/block_code_pkg.sv
// Shared constants and state encodings for the block-code framing controller.
package block_code_pkg;

  localparam int unsigned BC_DATA_WIDTH = 4;
  localparam int unsigned BC_MAX_LEN    = 15;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_t;

endpackage

// File: rtl/block_code_sym_bank.sv
// One codeword buffer: symbol memory, latched length and bank occupancy state.
module block_code_sym_bank
  import block_code_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BC_DATA_WIDTH,
  parameter int unsigned MAX_LEN    = BC_MAX_LEN,
  parameter int unsigned LW         = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_first,
  input  logic                  wr_last,
  input  logic [LW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LW-1:0]         len_in,
  input  logic                  rd_start,
  input  logic                  rd_done,
  input  logic [LW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_c,
  output bank_state_t           state,
  output logic [LW-1:0]         len
);

  logic [DATA_WIDTH-1:0] mem [MAX_LEN];
  bank_state_t           state_d;

  // Symbol storage carries no reset; stale contents are never read out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = (rd_addr < LW'(MAX_LEN)) ? mem[rd_addr] : '0;

  always_comb begin
    state_d = state;
    case (state)
      BANK_EMPTY:    if (wr_en && wr_first) state_d = BANK_FILLING;
      BANK_FILLING:  if (wr_en && wr_last)  state_d = BANK_FULL;
      BANK_FULL:     if (rd_start)          state_d = BANK_DRAINING;
      BANK_DRAINING: if (rd_done)           state_d = BANK_EMPTY;
      default:                              state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BANK_EMPTY;
      len   <= '0;
    end else begin
      state <= state_d;
      if (wr_en && wr_first) len <= len_in;
    end
  end

endmodule

// File: rtl/block_code_frame_ctrl.sv
// Ping-pong codeword framer feeding a block decoder over a valid/ready stream.
// Define BLOCK_CODE_FRAME_CNT_EN to build the frames_out / drops counters.
module block_code_frame_ctrl
  import block_code_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BC_DATA_WIDTH,
  parameter int unsigned MAX_LEN    = BC_MAX_LEN,
  localparam int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_symbols,
  input  logic                  rx_symbols_valid,
  input  logic [LW-1:0]         code_length,
  output logic [DATA_WIDTH-1:0] out_symbol,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic [LW-1:0]         out_len,
  output logic                  ovf,
  output logic                  cfg_err,
  output logic                  busy,
  output logic [15:0]           frames_out,
  output logic [15:0]           drops
);

  bank_state_t           bank_st [2];
  logic [LW-1:0]         bank_len [2];
  logic [DATA_WIDTH-1:0] bank_rd [2];
  logic [1:0]            bank_wr, bank_rd_start, bank_rd_done;

  logic [LW-1:0] wr_ptr, wr_ptr_d;
  logic          wr_bank, wr_bank_d, stall, stall_d, cfg_err_d;
  logic          wr_first_c, wr_last_c, drop_c, len_bad_c, other, other_empty_c;

  rd_state_t             rd_state, rd_state_d;
  logic                  rd_bank, rd_bank_d, rd_next, rd_next_d;
  logic [LW-1:0]         rd_idx, rd_idx_d, rd_addr_c;
  logic [DATA_WIDTH-1:0] out_symbol_d;
  logic                  out_valid_d, out_first_d, out_last_d;
  logic [LW-1:0]         out_len_d;

  block_code_sym_bank #(.DATA_WIDTH(DATA_WIDTH), .MAX_LEN(MAX_LEN), .LW(LW)) u_bank0 (
    .clk(clk), .rst(rst), .wr_en(bank_wr[0]), .wr_first(wr_first_c), .wr_last(wr_last_c),
    .wr_addr(wr_ptr), .wr_data(rx_symbols), .len_in(code_length),
    .rd_start(bank_rd_start[0]), .rd_done(bank_rd_done[0]), .rd_addr(rd_addr_c),
    .rd_data_c(bank_rd[0]), .state(bank_st[0]), .len(bank_len[0])
  );

  block_code_sym_bank #(.DATA_WIDTH(DATA_WIDTH), .MAX_LEN(MAX_LEN), .LW(LW)) u_bank1 (
    .clk(clk), .rst(rst), .wr_en(bank_wr[1]), .wr_first(wr_first_c), .wr_last(wr_last_c),
    .wr_addr(wr_ptr), .wr_data(rx_symbols), .len_in(code_length),
    .rd_start(bank_rd_start[1]), .rd_done(bank_rd_done[1]), .rd_addr(rd_addr_c),
    .rd_data_c(bank_rd[1]), .state(bank_st[1]), .len(bank_len[1])
  );

  assign other         = ~wr_bank;
  assign other_empty_c = (bank_st[other] == BANK_EMPTY) || bank_rd_done[other];
  assign len_bad_c     = (code_length < LW'(2)) || (32'(code_length) > 32'(MAX_LEN));
  assign busy          = (bank_st[0] != BANK_EMPTY) || (bank_st[1] != BANK_EMPTY);

  // Lookahead read address: symbol 0 while idle, next symbol while streaming.
  assign rd_addr_c = (rd_state == RD_STREAM) ? rd_idx + LW'(1) : '0;

  // Write side: fill, hand over to the other bank, or stall and drop.
  always_comb begin
    wr_ptr_d   = wr_ptr;
    wr_bank_d  = wr_bank;
    stall_d    = stall;
    cfg_err_d  = cfg_err;
    bank_wr    = '0;
    wr_first_c = 1'b0;
    wr_last_c  = 1'b0;
    drop_c     = 1'b0;
    if (stall) begin
      drop_c = rx_symbols_valid;
      if (bank_rd_done[other]) begin
        stall_d   = 1'b0;
        wr_bank_d = other;
      end
    end else if (rx_symbols_valid) begin
      if (wr_ptr == '0) begin
        if (len_bad_c) begin
          cfg_err_d = 1'b1;
        end else begin
          bank_wr[wr_bank] = 1'b1;
          wr_first_c       = 1'b1;
          wr_ptr_d         = LW'(1);
        end
      end else begin
        bank_wr[wr_bank] = 1'b1;
        if (wr_ptr == bank_len[wr_bank] - LW'(1)) begin
          wr_last_c = 1'b1;
          wr_ptr_d  = '0;
          if (other_empty_c) wr_bank_d = other;
          else               stall_d   = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr + LW'(1);
        end
      end
    end
  end

  // Read side: banks drain strictly in fill order, so rd_next tracks the oldest.
  always_comb begin
    rd_state_d    = rd_state;
    rd_bank_d     = rd_bank;
    rd_next_d     = rd_next;
    rd_idx_d      = rd_idx;
    out_valid_d   = out_valid;
    out_symbol_d  = out_symbol;
    out_first_d   = out_first;
    out_last_d    = out_last;
    out_len_d     = out_len;
    bank_rd_start = '0;
    bank_rd_done  = '0;
    case (rd_state)
      RD_IDLE: begin
        if (bank_st[rd_next] == BANK_FULL) begin
          rd_state_d             = RD_STREAM;
          rd_bank_d              = rd_next;
          rd_idx_d               = '0;
          bank_rd_start[rd_next] = 1'b1;
          out_valid_d            = 1'b1;
          out_symbol_d           = bank_rd[rd_next];
          out_first_d            = 1'b1;
          out_last_d             = (bank_len[rd_next] == LW'(1));
          out_len_d              = bank_len[rd_next];
        end
      end
      RD_STREAM: begin
        if (out_ready) begin
          if (out_last) begin
            bank_rd_done[rd_bank] = 1'b1;
            rd_state_d            = RD_IDLE;
            rd_next_d             = ~rd_next;
            out_valid_d           = 1'b0;
            out_symbol_d          = '0;
            out_first_d           = 1'b0;
            out_last_d            = 1'b0;
            out_len_d             = '0;
          end else begin
            rd_idx_d     = rd_idx + LW'(1);
            out_symbol_d = bank_rd[rd_bank];
            out_first_d  = 1'b0;
            out_last_d   = (rd_idx + LW'(1) == out_len - LW'(1));
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_bank    <= 1'b0;
      stall      <= 1'b0;
      cfg_err    <= 1'b0;
      ovf        <= 1'b0;
      rd_state   <= RD_IDLE;
      rd_bank    <= 1'b0;
      rd_next    <= 1'b0;
      rd_idx     <= '0;
      out_valid  <= 1'b0;
      out_symbol <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_len    <= '0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      wr_bank    <= wr_bank_d;
      stall      <= stall_d;
      cfg_err    <= cfg_err_d;
      ovf        <= drop_c;
      rd_state   <= rd_state_d;
      rd_bank    <= rd_bank_d;
      rd_next    <= rd_next_d;
      rd_idx     <= rd_idx_d;
      out_valid  <= out_valid_d;
      out_symbol <= out_symbol_d;
      out_first  <= out_first_d;
      out_last   <= out_last_d;
      out_len    <= out_len_d;
    end
  end

`ifdef BLOCK_CODE_FRAME_CNT_EN
  logic [15:0] frames_q, drops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (|bank_rd_done) frames_q <= frames_q + 16'd1;
      if (drop_c && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'd1;
    end
  end

  assign frames_out = frames_q;
  assign drops      = drops_q;
`else
  assign frames_out = '0;
  assign drops      = '0;
`endif

endmodule

// File: tb/tb_block_code_frame_ctrl.sv
// Directed self-checking bench for block_code_frame_ctrl (default parameters).
`timescale 1ns/1ps
module tb_block_code_frame_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_symbols = '0;
  logic          rx_symbols_valid = 1'b0;
  logic [LW-1:0] code_length = '0;
  logic [DW-1:0] out_symbol;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_first, out_last;
  logic [LW-1:0] out_len;
  logic          ovf, cfg_err, busy;
  logic [15:0]   frames_out, drops;

  int errors = 0;
  int checks = 0;

  logic [9:0] acc_q [$];
  logic [9:0] exp_q [$];
  int ovf_cnt = 0, valid_cyc = 0, busy_cyc = 0;
  int acc_base = 0, ovf_base = 0, valid_base = 0, busy_base = 0;

  block_code_frame_ctrl dut (
    .clk(clk), .rst(rst), .rx_symbols(rx_symbols), .rx_symbols_valid(rx_symbols_valid),
    .code_length(code_length), .out_symbol(out_symbol), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last), .out_len(out_len),
    .ovf(ovf), .cfg_err(cfg_err), .busy(busy), .frames_out(frames_out), .drops(drops)
  );

  always #5 clk = ~clk;

  // Observe the stream mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) acc_q.push_back({out_first, out_last, out_len, out_symbol});
      if (ovf)       ovf_cnt++;
      if (out_valid) valid_cyc++;
      if (busy)      busy_cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx_symbols_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_base   = acc_q.size();
    ovf_base   = ovf_cnt;
    valid_base = valid_cyc;
    busy_base  = busy_cyc;
    exp_q.delete();
  endtask

  task automatic send(input int n, input int start, input int len);
    for (int i = 0; i < n; i++) begin
      rx_symbols       = DW'(start + i);
      rx_symbols_valid = 1'b1;
      code_length      = LW'(len);
      @(posedge clk);
      #1;
    end
    rx_symbols_valid = 1'b0;
  endtask

  task automatic expect_frame(input int start, input int len);
    logic [9:0] e;
    for (int k = 0; k < len; k++) begin
      e = {1'(k == 0), 1'(k == len - 1), LW'(len), DW'(start + k)};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_acc(input int n);
    for (int c = 0; c < 400 && (acc_q.size() - acc_base) < n; c++) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    int n;
    n = acc_q.size() - acc_base;
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check({tag, "_sym"}, acc_q[acc_base + i], exp_q[i]);
  endtask

  initial begin
    int exp_fr2, exp_dr13, exp_fr3, exp_dr2;
`ifdef BLOCK_CODE_FRAME_CNT_EN
    exp_fr2 = 2; exp_dr13 = 13; exp_fr3 = 3; exp_dr2 = 2;
`else
    exp_fr2 = 0; exp_dr13 = 0;  exp_fr3 = 0; exp_dr2 = 0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_symbol", out_symbol, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_frames_out", frames_out, 0);
    check("rst_drops", drops, 0);

    // Two back-to-back frames of 13, consumer always ready
    apply_reset();
    out_ready = 1'b1;
    expect_frame(0, 13);
    expect_frame(13, 13);
    send(26, 0, 13);
    wait_acc(26);
    repeat (3) @(posedge clk);
    #1;
    compare("t1");
    check("t1_ovf", ovf_cnt - ovf_base, 0);
    check("t1_busy_end", busy, 0);

    // Backpressure: frames 1-2 held, frame 3 dropped entirely
    apply_reset();
    send(39, 0, 13);
    repeat (5) @(posedge clk);
    #1;
    check("t2_ovf", ovf_cnt - ovf_base, 13);
    check("t2_held", {out_valid, out_first, out_len, out_symbol}, {1'b1, 1'b1, 4'd13, 4'd0});
    check("t2_busy", busy, 1);
    out_ready = 1'b1;
    expect_frame(0, 13);
    expect_frame(13, 13);
    wait_acc(26);
    repeat (20) @(posedge clk);
    #1;
    compare("t2");
    check("t2_frames_out", frames_out, exp_fr2);
    check("t2_drops", drops, exp_dr13);
    check("t2_busy_end", busy, 0);

    // Length change mid-frame applies to the next frame only
    apply_reset();
    out_ready = 1'b1;
    send(5, 0, 13);
    send(8, 5, 7);
    send(7, 13, 7);
    expect_frame(0, 13);
    expect_frame(13, 7);
    wait_acc(20);
    repeat (3) @(posedge clk);
    #1;
    compare("t3");
    check("t3_ovf", ovf_cnt - ovf_base, 0);

    // Illegal length, then the smallest and largest legal lengths
    apply_reset();
    out_ready = 1'b1;
    send(1, 0, 1);
    check("t4_cfg_err", cfg_err, 1);
    send(3, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_valid", valid_cyc - valid_base, 0);
    check("t4_no_busy", busy_cyc - busy_base, 0);
    check("t4_no_ovf", ovf_cnt - ovf_base, 0);
    send(2, 4, 2);
    send(15, 6, 15);
    expect_frame(4, 2);
    expect_frame(6, 15);
    wait_acc(17);
    compare("t4");
    check("t4_cfg_err_sticky", cfg_err, 1);

    // First-symbol latency, asynchronous reset mid-frame, then a clean frame
    apply_reset();
    send(13, 0, 13);
    check("t5_valid_before", out_valid, 0);
    check("t5_busy_full", busy, 1);
    @(posedge clk);
    #1;
    check("t5_first_out", {out_valid, out_first, out_len, out_symbol}, {1'b1, 1'b1, 4'd13, 4'd0});
    send(5, 13, 13);
    rst = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_len", out_len, 0);
    apply_reset();
    send(13, 3, 13);
    expect_frame(3, 13);
    out_ready = 1'b1;
    wait_acc(13);
    repeat (3) @(posedge clk);
    #1;
    compare("t5");

    // Three frames and two drops for the counters
    apply_reset();
    send(28, 0, 13);
    repeat (3) @(posedge clk);
    #1;
    check("t6_ovf", ovf_cnt - ovf_base, 2);
    out_ready = 1'b1;
    wait_acc(26);
    send(13, 28, 13);
    expect_frame(0, 13);
    expect_frame(13, 13);
    expect_frame(28, 13);
    wait_acc(39);
    repeat (20) @(posedge clk);
    #1;
    compare("t6");
    check("t6_frames_out", frames_out, exp_fr3);
    check("t6_drops", drops, exp_dr2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
